// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types for the register file and its select logic.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_GP   = 5'd28;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: r0 forcing plus optional same-cycle write bypass.
// Bypass is built only when REGFILE_WRITE_BYPASS_EN is defined.
module reg_file_read_port
  import mips_pkg::*;
(
  input  reg_idx_t rd_addr,
  input  word_t    stored,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic     byp_en,
  input  reg_idx_t wr_addr,
  input  word_t    wr_data,
`endif
  output word_t    rd_data
);

  always_comb begin
    rd_data = stored;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (byp_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
`endif
    // r0 wins over bypass so it can never read nonzero
    if (rd_addr == REG_ZERO) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_file_32x32.sv
// MIPS 32x32 register file: two combinational reads, one synchronous write, write counter.
// Optional same-cycle write-to-read bypass selected by REGFILE_WRITE_BYPASS_EN.
module reg_file_32x32
  import mips_pkg::*;
#(
  parameter word_t SP_RESET = 32'h0000_3FFC,
  parameter word_t GP_RESET = 32'h0000_1800
) (
  input  logic     clk,
  input  logic     rst,
  input  reg_idx_t rd_addr1,
  input  reg_idx_t rd_addr2,
  output word_t    rd_data1,
  output word_t    rd_data2,
  input  logic     wr_en,
  input  reg_idx_t wr_addr,
  input  word_t    wr_data,
  output cnt_t     wr_count
);

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];
  cnt_t  cnt_q;
  cnt_t  cnt_d;

  // Writes to r0 are dropped and do not count
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wr_en && (wr_addr != REG_ZERO)) begin
      regs_d[wr_addr] = wr_data;
      cnt_d           = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[REG_GP] <= GP_RESET;
      regs_q[REG_SP] <= SP_RESET;
      cnt_q          <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wr_count = cnt_q;

`ifdef REGFILE_WRITE_BYPASS_EN
  // Suppress bypass during reset so reads show reset values
  logic byp_en;
  assign byp_en = wr_en & ~rst;
`endif

  reg_file_read_port u_rd_port1 (
    .rd_addr (rd_addr1),
    .stored  (regs_q[rd_addr1]),
`ifdef REGFILE_WRITE_BYPASS_EN
    .byp_en  (byp_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .rd_data (rd_data1)
  );

  reg_file_read_port u_rd_port2 (
    .rd_addr (rd_addr2),
    .stored  (regs_q[rd_addr2]),
`ifdef REGFILE_WRITE_BYPASS_EN
    .byp_en  (byp_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .rd_data (rd_data2)
  );

endmodule
